// File: rtl/arb_rr_nch.sv
// N-channel round-robin arbiter: grants one slave stream for a whole transaction and
// forwards its beats through a registered master-side stage.
module arb_rr_nch #(
    parameter int NUM_SLV   = 4,
    parameter int DW        = 32,
    parameter int MODE_W    = 2,
    parameter int PROC_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int SEL_W     = $clog2(NUM_SLV)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SLV*MODE_W-1:0] slv_mode,
    input  logic [NUM_SLV-1:0]        slv_data_valid,
    input  logic [NUM_SLV*PROC_W-1:0] slv_proc_valid,
    input  logic [NUM_SLV*DW-1:0]     slv_data,
    output logic [NUM_SLV-1:0]        slv_ready,
    input  logic                      fifo_full,
    input  logic                      mstr0_cmplt,
    output logic [MODE_W-1:0]         slvx_mode,
    output logic                      slvx_data_valid,
    output logic [PROC_W-1:0]         slvx_proc_val,
    output logic [DW-1:0]             slvx_data,
    output logic [SEL_W-1:0]          data_source,
    output logic                      busy
);

    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StXfer = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [SEL_W-1:0]  rr_q, rr_d;
    logic [SEL_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [PROC_W-1:0] out_proc_q, out_proc_d;
    logic [DW-1:0]     out_data_q, out_data_d;

    logic [DW-1:0]     data_arr [NUM_SLV];
    logic [PROC_W-1:0] proc_arr [NUM_SLV];
    logic [MODE_W-1:0] mode_arr [NUM_SLV];

    for (genvar i = 0; i < NUM_SLV; i++) begin : g_unpack
        assign data_arr[i] = slv_data[i*DW +: DW];
        assign proc_arr[i] = slv_proc_valid[i*PROC_W +: PROC_W];
        assign mode_arr[i] = slv_mode[i*MODE_W +: MODE_W];
    end

    // First requester at or above the rr pointer, wrapping.
    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    int               idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_SLV; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_SLV) begin
                idx = idx - NUM_SLV;
            end
            if (!win_found && slv_data_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = SEL_W'(idx);
            end
        end
    end

    logic             xfer;
    logic             beat;
    logic             cap_hit;
    logic             release_grant;
    logic [CNT_W-1:0] cnt_inc;
    logic [SEL_W-1:0] rr_next;

    always_comb begin
        xfer          = (state_q == StXfer);
        beat          = xfer && slv_data_valid[grant_q] && !fifo_full;
        cnt_inc       = cnt_q + CNT_W'(1);
        cap_hit       = (MAX_BURST != 0) && beat && (cnt_inc == CNT_W'(MAX_BURST));
        release_grant = xfer && (mstr0_cmplt || cap_hit);
        rr_next       = (grant_q == SEL_W'(NUM_SLV - 1)) ? '0 : grant_q + SEL_W'(1);
    end

    always_comb begin
        slv_ready = '0;
        if (xfer && !rst) begin
            slv_ready[grant_q] = ~fifo_full;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        out_valid_d = beat;
        out_proc_d  = out_proc_q;
        out_data_d  = out_data_q;

        if (beat) begin
            out_data_d = data_arr[grant_q];
            out_proc_d = proc_arr[grant_q];
            if (MAX_BURST != 0 && cnt_q != CNT_W'(MAX_BURST)) begin
                cnt_d = cnt_inc;
            end
        end

        if (state_q == StIdle) begin
            if (win_found) begin
                grant_d = win_idx;
                mode_d  = mode_arr[win_idx];
                busy_d  = 1'b1;
                state_d = StXfer;
            end
        end else if (release_grant) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            rr_d    = rr_next;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_q        <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_proc_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_proc_q  <= out_proc_d;
            out_data_q  <= out_data_d;
        end
    end

    assign slvx_mode       = mode_q;
    assign slvx_data_valid = out_valid_q;
    assign slvx_proc_val   = out_proc_q;
    assign slvx_data       = out_data_q;
    assign data_source     = grant_q;
    assign busy            = busy_q;

endmodule
